lcd_bus_driver: RTL
===================

// Module: lcd_bus_driver
// PURPOSE
//  Write-only HD44780 bus timing engine downstream of the character/screen sequencer.
//  - Runs the LCD power-up init sequence.
//  - Accepts one 10-bit word {RS,RW,D[7:0]} per ENB/RDY handshake.
//  - Drives RS/RW/E/DB pins with setup, pulse and hold timing.
//  - Holds RDY low for each command's execution time.
// PARAMETERS
//  T_POWERUP   750000  cycles after reset before first init write (15 ms @ 50 MHz)
//  T_SETUP     4       cycles RS/RW/DB stable before E rises
//  T_EPULSE    13      cycles E held high
//  T_HOLD      2       cycles RS/RW/DB held after E falls
//  T_CMD_WAIT  2500    execution wait, ordinary command/data (50 us)
//  T_CLR_WAIT  82000   execution wait, clear (0x01) / return-home (0x02,0x03)
//  T_INIT1     205000  wait after 1st init function-set (4.1 ms)
//  T_INIT2     5000    wait after 2nd init function-set (100 us)
// PORTS
//  CLK        in   1   system clock, all logic on posedge
//  RST        in   1   synchronous, active-high reset
//  DATA_IN    in   10  [9]=RS, [8]=RW (ignored, writes only), [7:0]=byte
//  ENB        in   1   write strobe from sequencer
//  RDY        out  1   1 = idle, next word may be issued
//  INIT_DONE  out  1   1 once init sequence completed; stays 1 until RST
//  LCD_RS     out  1   LCD register select
//  LCD_RW     out  1   LCD read/write, constant 0
//  LCD_E      out  1   LCD enable strobe
//  LCD_DB     out  8   LCD data bus
// BEHAVIOUR
//  - Reset values (all outputs registered), applied at the first posedge with RST=1:
//    - RDY, INIT_DONE, LCD_RS, LCD_RW, LCD_E = 0; LCD_DB = 8'h00.
//    - FSM enters PWRUP_WAIT; delay counter cleared.
//  - RST mid-operation: E drops at that same edge and the sequence restarts from PWRUP_WAIT. No partial word is completed.
//  - FSM states: PWRUP_WAIT -> INIT_LOAD -> SETUP -> E_HIGH -> HOLD -> EXEC_WAIT, then either INIT_LOAD (init entries left) or IDLE.
//  - Init ROM, all RS=0, in order: 38,38,38,38,0C,01,06.
//    - Wait after entry0 = T_INIT1; after entry1 = T_INIT2.
//    - Wait after 01 = T_CLR_WAIT; after all others = T_CMD_WAIT.
//  - INIT_DONE and RDY go 1 at the edge leaving the final EXEC_WAIT.
//  - Handshake:
//    - A word is accepted at a posedge where ENB=1 and RDY=1 (RDY as registered, i.e. pre-edge value).
//    - At that edge: RDY<=0; DATA_IN is latched onto LCD_RS/LCD_DB; FSM enters SETUP.
//    - ENB while RDY=0 is ignored, not queued.
//    - ENB held high is consumed once per RDY high period.
//  - Timing for an accepted word, counted in CLK edges from the acceptance edge:
//    - SETUP: T_SETUP cycles, E=0.
//    - E_HIGH: T_EPULSE cycles, E=1.
//    - HOLD: T_HOLD cycles, E=0, bus unchanged.
//    - EXEC_WAIT: W cycles.
//    - RDY returns to 1 on the edge ending EXEC_WAIT.
//    - Total RDY-low time = T_SETUP+T_EPULSE+T_HOLD+W.
//  - W rule: W = T_CLR_WAIT when RS=0 and byte in {01,02,03}; otherwise W = T_CMD_WAIT.
//  - LCD_DB and LCD_RS change only on acceptance or INIT_LOAD, never while E=1.
//  - Delay counter: one down-counter, width $clog2(max of all T_* params)+1, loaded at each state entry.
//    - Every parameter value >= 1 is legal; a parameter of 1 gives exactly one cycle in that state.
// TESTING
//  Run the bench with small parameters: T_POWERUP=20, T_SETUP=2, T_EPULSE=3, T_HOLD=1,
//  T_CMD_WAIT=5, T_CLR_WAIT=40, T_INIT1=10, T_INIT2=6.
//  1. Reset release -> 7 E pulses, each 3 cycles wide, with DB=38,38,38,38,0C,01,06 and RS=0.
//     Gaps between pulses match the wait table; INIT_DONE=RDY=1 afterwards; ENB pulses during init are ignored.
//  2. One-cycle ENB with DATA_IN=10'h241 -> RS=1, DB=41, E high on cycles 3-5 after acceptance.
//     RDY low for 11 cycles, then high.
//  3. DATA_IN=10'h001 -> RDY low for exactly 2+3+1+40 = 46 cycles; same for 10'h002.
//     10'h201 (RS=1) -> RDY low for 11 cycles.
//  4. Sequencer-style traffic (ENB toggling, issued only while RDY=1), 36 CGRAM words -> 36 E pulses, none dropped or duplicated.
//     ENB held high continuously -> one write per RDY window.
//  5. RST asserted while E=1 -> next edge E=0, RDY=0, INIT_DONE=0; full init sequence replays.
//  6. DATA_IN[8]=1 -> LCD_RW stays 0; write proceeds normally.

Source files
------------

// File: rtl/lcd_bus_driver.sv
// Write-only HD44780 bus timing engine: power-up init, then one {RS,RW,D} word per handshake.
// Latency: word accepted on the edge enb_i=1 & rdy_o=1; E rises T_SETUP cycles later.
// Backpressure: rdy_o low for setup+pulse+hold+execution wait; enb_i while rdy_o=0 is dropped.
//
// Ports:
//   clk_i         system clock, all logic on posedge
//   rst_i         synchronous active-high reset
//   data_in_i     [9]=RS, [8]=RW (ignored, writes only), [7:0]=byte
//   enb_i         write strobe from the sequencer
//   rdy_o         1 = idle, next word may be issued
//   init_done_o   1 once the init sequence completed, held until reset
//   lcd_rs_o/lcd_rw_o/lcd_e_o/lcd_db_o   registered LCD pins (lcd_rw_o is always 0)
module lcd_bus_driver #(
    parameter int T_POWERUP  = 750000,
    parameter int T_SETUP    = 4,
    parameter int T_EPULSE   = 13,
    parameter int T_HOLD     = 2,
    parameter int T_CMD_WAIT = 2500,
    parameter int T_CLR_WAIT = 82000,
    parameter int T_INIT1    = 205000,
    parameter int T_INIT2    = 5000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [9:0] data_in_i,
    input  logic       enb_i,
    output logic       rdy_o,
    output logic       init_done_o,
    output logic       lcd_rs_o,
    output logic       lcd_rw_o,
    output logic       lcd_e_o,
    output logic [7:0] lcd_db_o
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int T_MAX = max2(max2(max2(T_POWERUP, T_SETUP), max2(T_EPULSE, T_HOLD)),
                                max2(max2(T_CMD_WAIT, T_CLR_WAIT), max2(T_INIT1, T_INIT2)));
    localparam int CW = $clog2(T_MAX) + 1;
    typedef logic [CW-1:0] cnt_t;

    localparam logic [2:0] LAST_IDX = 3'd6;

    typedef enum logic [2:0] {
        PWRUP_WAIT, INIT_LOAD, IDLE, SETUP, E_HIGH, HOLD, EXEC_WAIT
    } state_t;

    function automatic logic [7:0] rom_byte(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2, 3'd3: rom_byte = 8'h38;
            3'd4:                   rom_byte = 8'h0C;
            3'd5:                   rom_byte = 8'h01;
            3'd6:                   rom_byte = 8'h06;
            default:                rom_byte = 8'h00;
        endcase
    endfunction

    state_t     state_q, state_d;
    cnt_t       cnt_q, cnt_d;
    logic [2:0] idx_q, idx_d;
    logic       rs_q, rs_d;
    logic [7:0] db_q, db_d;
    logic       e_q, e_d;
    logic       rdy_q, rdy_d;
    logic       done_q, done_d;
    logic       rw_q;
    cnt_t       wait_sel;
    logic       cnt_zero;
    logic       accept;
    logic       rw_unused;

    // The RW bit of a word has no effect: the bus only ever writes.
    assign rw_unused = data_in_i[8];

    assign cnt_zero = (cnt_q == '0);
    assign accept   = (state_q == IDLE) && enb_i && rdy_q;

    // Execution wait for the word currently on the bus. The first two init
    // entries have their own long waits; clear/return-home are slow commands.
    always_comb begin
        wait_sel = cnt_t'(T_CMD_WAIT);
        if (!done_q && idx_q == 3'd0) begin
            wait_sel = cnt_t'(T_INIT1);
        end else if (!done_q && idx_q == 3'd1) begin
            wait_sel = cnt_t'(T_INIT2);
        end else if (!rs_q && (db_q == 8'h01 || db_q == 8'h02 || db_q == 8'h03)) begin
            wait_sel = cnt_t'(T_CLR_WAIT);
        end
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= PWRUP_WAIT;
            cnt_q   <= '0;
            idx_q   <= '0;
            rs_q    <= 1'b0;
            db_q    <= 8'h00;
            e_q     <= 1'b0;
            rdy_q   <= 1'b0;
            done_q  <= 1'b0;
            rw_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rs_q    <= rs_d;
            db_q    <= db_d;
            e_q     <= e_d;
            rdy_q   <= rdy_d;
            done_q  <= done_d;
            rw_q    <= 1'b0;
        end
    end

    // Next-state logic. The counter is loaded with (T-1) on entry so a state
    // lasts exactly T cycles; the power-up wait starts from the cleared
    // counter and counts up instead, giving T_POWERUP cycles after reset.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        case (state_q)
            PWRUP_WAIT: begin
                if (cnt_q == cnt_t'(T_POWERUP - 1)) begin
                    state_d = INIT_LOAD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end
            INIT_LOAD: begin
                state_d = SETUP;
                cnt_d   = cnt_t'(T_SETUP - 1);
            end
            IDLE: begin
                if (accept) begin
                    state_d = SETUP;
                    cnt_d   = cnt_t'(T_SETUP - 1);
                end
            end
            SETUP: begin
                if (cnt_zero) begin
                    state_d = E_HIGH;
                    cnt_d   = cnt_t'(T_EPULSE - 1);
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            E_HIGH: begin
                if (cnt_zero) begin
                    state_d = HOLD;
                    cnt_d   = cnt_t'(T_HOLD - 1);
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            HOLD: begin
                if (cnt_zero) begin
                    state_d = EXEC_WAIT;
                    cnt_d   = wait_sel - cnt_t'(1);
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            EXEC_WAIT: begin
                if (cnt_zero) begin
                    cnt_d = '0;
                    if (done_q || idx_q == LAST_IDX) begin
                        state_d = IDLE;
                    end else begin
                        state_d = INIT_LOAD;
                        idx_d   = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            default: begin
                state_d = PWRUP_WAIT;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic: next values of the registered pins. The bus is loaded
    // only from the init ROM or on acceptance, so it can never move under E.
    always_comb begin
        rs_d = rs_q;
        db_d = db_q;
        if (state_q == INIT_LOAD) begin
            rs_d = 1'b0;
            db_d = rom_byte(idx_q);
        end else if (accept) begin
            rs_d = data_in_i[9];
            db_d = data_in_i[7:0];
        end
        e_d    = (state_d == E_HIGH);
        rdy_d  = (state_d == IDLE);
        // IDLE is only reachable once the init ROM has been played out.
        done_d = done_q | (state_d == IDLE);
    end

    assign rdy_o       = rdy_q;
    assign init_done_o = done_q;
    assign lcd_rs_o    = rs_q;
    assign lcd_rw_o    = rw_q;
    assign lcd_e_o     = e_q;
    assign lcd_db_o    = db_q;

endmodule
